// File: rtl/weight_update_ctrl_if.sv
// weight_update_ctrl_if: bundles the weight RAM initiator port, the gradient
// handshake and the pass control signals of weight_update_ctrl.
//   Start/Busy/Done        : pass control
//   GradReq/GradValid/Grad : per-block gradient handshake, lane i <-> word Address+i
//   Address/WE/D/Q         : RAM port; Q is registered by the RAM one edge after a read
// master = the update engine, slave = the RAM/gradient side.
interface weight_update_ctrl_if #(
  parameter int N  = 10,
  parameter int AW = 7
);
  logic              Start;
  logic              Busy;
  logic              Done;
  logic              GradReq;
  logic              GradValid;
  logic [N-1:0][9:0] Grad;
  logic [AW-1:0]     Address;
  logic              WE;
  logic [N-1:0][9:0] D;
  logic [N-1:0][9:0] Q;

  modport master (
    input  Start, GradValid, Grad, Q,
    output Address, WE, D, GradReq, Busy, Done
  );

  modport slave (
    output Start, GradValid, Grad, Q,
    input  Address, WE, D, GradReq, Busy, Done
  );
endinterface

// File: rtl/weight_update_ctrl.sv
// weight_update_ctrl: read-modify-write engine for the weight RAM. One pass
// walks the RAM in blocks of N words (floor(DEPTH/N) blocks, trailing words
// untouched). Per block: read N weights, wait for N gradients, write back
// sat10(W - (Grad >>> SHIFT)).
// Ports:
//   Clock - rising-edge clock
//   Rst   - asynchronous active-low reset
//   bus   - weight_update_ctrl_if.master (RAM port, gradient handshake, control)

// One lane of the update datapath: w - (g >>> SHIFT), clamped to 10-bit signed.
module weight_update_ctrl_lane #(
  parameter int SHIFT = 4
) (
  input  logic [9:0] w_i,
  input  logic [9:0] g_i,
  output logic [9:0] d_o
);
  logic signed [9:0]  g_sh;
  logic signed [10:0] diff;

  assign g_sh = $signed(g_i) >>> SHIFT;
  // 11 bits cannot overflow for two 10-bit operands; bits [10:9] disagreeing
  // means the result is outside [-512, 511].
  assign diff = {w_i[9], w_i} - {g_sh[9], g_sh};

  always_comb begin
    d_o = diff[9:0];
    if (diff[10] != diff[9]) d_o = diff[10] ? 10'h200 : 10'h1FF;
  end
endmodule

module weight_update_ctrl #(
  parameter int N     = 10,
  parameter int DEPTH = 65,
  parameter int SHIFT = 4
) (
  input  logic                  Clock,
  input  logic                  Rst,
  weight_update_ctrl_if.master  bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_GRAD = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [6:0]        base_q, base_d;
  logic [N-1:0][9:0] wreg_q, wreg_d;
  logic [N-1:0][9:0] d_q, d_d;
  logic [N-1:0][9:0] upd;
  logic              last_blk;

  for (genvar i = 0; i < N; i++) begin : g_lane
    weight_update_ctrl_lane #(.SHIFT(SHIFT)) u_lane (
      .w_i (wreg_q[i]),
      .g_i (bus.Grad[i]),
      .d_o (upd[i])
    );
  end

  // No room for another full block after this one.
  assign last_blk = (int'(base_q) + 2 * N) > DEPTH;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wreg_d  = wreg_q;
    d_d     = d_q;
    case (state_q)
      S_IDLE: if (bus.Start) begin
        state_d = S_RD;
        base_d  = '0;
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        wreg_d  = bus.Q;
        state_d = S_GRAD;
      end
      S_GRAD: if (bus.GradValid) begin
        d_d     = upd;
        state_d = S_WR;
      end
      S_WR: begin
        if (last_blk) state_d = S_DONE;
        else begin
          base_d  = base_q + 7'(N);
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      wreg_q  <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wreg_q  <= wreg_d;
      d_q     <= d_d;
    end
  end

  // Address is held for the whole block and forced to 0 when no block is active.
  assign bus.Address = (state_q inside {S_RD, S_CAP, S_GRAD, S_WR}) ? base_q : '0;
  assign bus.WE      = (state_q == S_WR);
  assign bus.GradReq = (state_q == S_GRAD);
  assign bus.Busy    = (state_q != S_IDLE);
  assign bus.Done    = (state_q == S_DONE);
  assign bus.D       = d_q;
endmodule

// File: tb/tb_weight_update_ctrl.sv
module tb_weight_update_ctrl;
  localparam int N     = 10;
  localparam int DEPTH = 65;
  localparam int SHIFT = 4;
  localparam int NBLK  = DEPTH / N;

  logic Clock = 1'b0;
  logic Rst   = 1'b0;

  weight_update_ctrl_if #(.N(N)) bus ();
  weight_update_ctrl #(.N(N), .DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
    .Clock (Clock),
    .Rst   (Rst),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model (registered read, write when WE) -------------
  int ram [DEPTH];
  int img [DEPTH];
  bit load_pend = 1'b0;

  always @(posedge Clock) begin
    if (load_pend) begin
      for (int a = 0; a < DEPTH; a++) ram[a] = img[a];
    end else if (bus.WE) begin
      for (int i = 0; i < N; i++)
        if (int'(bus.Address) + i < DEPTH) ram[int'(bus.Address) + i] = int'($signed(bus.D[i]));
    end else begin
      for (int i = 0; i < N; i++)
        bus.Q[i] <= (int'(bus.Address) + i < DEPTH) ? 10'(ram[int'(bus.Address) + i]) : 10'd0;
    end
  end

  // ---------------- reference model ----------------------------------------
  int gold [DEPTH];
  bit m_busy = 0, m_done = 0;
  int m_blk = 0, m_step = 0;   // step: 0 read, 1 capture, 2 await grad, 3 write
  int m_d [N];

  function automatic int floor_shift(input int g);
    int q;
    q = g / (1 << SHIFT);
    if (g < 0 && (g % (1 << SHIFT)) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int sat10(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  always @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      m_busy = 0; m_done = 0; m_blk = 0; m_step = 0;
      for (int i = 0; i < N; i++) m_d[i] = 0;
    end else begin
      if (load_pend) for (int a = 0; a < DEPTH; a++) gold[a] = img[a];
      if (m_done) m_done = 0;
      else if (!m_busy) begin
        if (bus.Start) begin m_busy = 1; m_blk = 0; m_step = 0; end
      end else begin
        case (m_step)
          0, 1: m_step = m_step + 1;
          2: if (bus.GradValid) begin
            for (int i = 0; i < N; i++)
              m_d[i] = sat10(gold[m_blk*N + i] - floor_shift(int'($signed(bus.Grad[i]))));
            m_step = 3;
          end
          default: begin
            for (int i = 0; i < N; i++) gold[m_blk*N + i] = m_d[i];
            if (m_blk == NBLK - 1) begin m_busy = 0; m_done = 1; end
            else begin m_blk = m_blk + 1; m_step = 0; end
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare --------------------------------------
  int we_tot = 0, done_tot = 0, gr20_tot = 0;
  bit we_prev = 0;

  always @(negedge Clock) begin
    chk("Address", int'(bus.Address), m_busy ? m_blk*N : 0);
    chk("WE", int'(bus.WE), int'(m_busy && m_step == 3));
    chk("GradReq", int'(bus.GradReq), int'(m_busy && m_step == 2));
    chk("Busy", int'(bus.Busy), int'(m_busy || m_done));
    chk("Done", int'(bus.Done), int'(m_done));
    for (int i = 0; i < N; i++) chk("D", int'($signed(bus.D[i])), m_d[i]);
    chk("WE_back_to_back", int'(we_prev && bus.WE), 0);
    we_prev = bus.WE;
    if (bus.WE) we_tot++;
    if (bus.Done) done_tot++;
    if (bus.GradReq && bus.Address == 7'd20) gr20_tot++;
  end

  // ---------------- gradient driver ----------------------------------------
  int gv_mode   = 0;   // 0 tied high, 1 random, 2 stall 5 cycles at block 2
  bit grad_rand = 0;
  int gpat [N];
  int stalled   = 0;

  always @(posedge Clock) begin
    #1;
    if (!bus.Busy) stalled = 0;
    case (gv_mode)
      1: bus.GradValid = ($urandom_range(0, 3) != 0);
      2: if (bus.GradReq && bus.Address == 7'd20 && stalled < 5) begin
           bus.GradValid = 1'b0;
           stalled++;
         end else bus.GradValid = 1'b1;
      default: bus.GradValid = 1'b1;
    endcase
    for (int i = 0; i < N; i++) bus.Grad[i] = grad_rand ? 10'($urandom) : 10'(gpat[i]);
  end

  // ---------------- helpers ------------------------------------------------
  task automatic do_load();
    load_pend = 1'b1;
    @(posedge Clock); #1;
    load_pend = 1'b0;
  endtask

  task automatic fill(input int v);
    for (int a = 0; a < DEPTH; a++) img[a] = v;
  endtask

  task automatic set_grad(input int v);
    for (int i = 0; i < N; i++) gpat[i] = v;
  endtask

  function automatic int count_eq(input int lo, input int hi, input int v);
    int c = 0;
    for (int a = lo; a <= hi; a++) if (ram[a] == v) c++;
    return c;
  endfunction

  task automatic cmp_model(input string name);
    int m = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] != gold[a]) m++;
    chk(name, m, 0);
  endtask

  // Starts a pass (Start high for edge 0); cycle k is the k-th cycle after
  // edge 0. Optionally pulses Start at cycle pulse_k, pulses Start during the
  // Done cycle, or drops Rst when block rst_blk reaches its gradient wait.
  task automatic run_pass(input int pulse_k, input bit start_in_done,
                          input int rst_blk, output int done_k);
    done_k = -1;
    @(posedge Clock); #1 bus.Start = 1'b1;
    @(posedge Clock); #1 bus.Start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge Clock);
      if (rst_blk >= 0 && bus.GradReq && int'(bus.Address) == rst_blk*N) begin
        #2 Rst = 1'b0;
        #1;
        chk("rst_Address", int'(bus.Address), 0);
        chk("rst_WE", int'(bus.WE), 0);
        chk("rst_D_zero", int'(bus.D == '0), 1);
        chk("rst_GradReq", int'(bus.GradReq), 0);
        chk("rst_Busy", int'(bus.Busy), 0);
        chk("rst_Done", int'(bus.Done), 0);
        @(negedge Clock); #2 Rst = 1'b1;
        return;
      end
      if (bus.Done) begin
        done_k = k;
        if (start_in_done) begin
          #2 bus.Start = 1'b1;
          @(posedge Clock); #1 bus.Start = 1'b0;
        end
        @(negedge Clock);
        chk("idle_after_done", int'(bus.Busy), 0);
        return;
      end
      if (k == pulse_k) begin #2 bus.Start = 1'b1; end
      else if (k == pulse_k + 1) begin #2 bus.Start = 1'b0; end
    end
    n_chk++;
    n_fail++;
    $display("FAIL pass_timeout: got no Done required Done within 400 cycles");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ------------------------------------------
  initial begin
    int dc, we0, dn0, gr0;
    bus.Start = 1'b0;
    set_grad(0);
    fill(0);

    repeat (3) @(negedge Clock);
    chk("reset_Address", int'(bus.Address), 0);
    chk("reset_WE", int'(bus.WE), 0);
    chk("reset_D_zero", int'(bus.D == '0), 1);
    chk("reset_GradReq", int'(bus.GradReq), 0);
    chk("reset_Busy", int'(bus.Busy), 0);
    chk("reset_Done", int'(bus.Done), 0);
    #2 Rst = 1'b1;

    // Zero RAM, Grad +16 everywhere: words 0-59 -> -1, tail untouched.
    fill(0); set_grad(16); do_load();
    we0 = we_tot; dn0 = done_tot;
    run_pass(-1, 0, -1, dc);
    chk("t1_done_cycle", dc, 25);
    chk("t1_we_pulses", we_tot - we0, 6);
    chk("t1_done_pulses", done_tot - dn0, 1);
    chk("t1_words_minus1", count_eq(0, 59, -1), 60);
    chk("t1_tail_zero", count_eq(60, 64, 0), 5);
    cmp_model("t1_model");

    // Saturation at both rails.
    fill(0); img[0] = -512; img[1] = 511;
    set_grad(0); gpat[0] = 511; gpat[1] = -512;
    do_load();
    run_pass(-1, 0, -1, dc);
    chk("t2_sat_neg", ram[0], -512);
    chk("t2_sat_pos", ram[1], 511);
    chk("t2_zero_grad", ram[2], 0);
    cmp_model("t2_model");

    // Floor shift: -17 -> -2 so words become +2; +15 -> 0 so words stay 0.
    fill(0); set_grad(-17); do_load();
    run_pass(-1, 0, -1, dc);
    chk("t3_floor_neg", count_eq(0, 59, 2), 60);
    fill(0); set_grad(15); do_load();
    run_pass(-1, 0, -1, dc);
    chk("t3_small_pos", count_eq(0, 64, 0), 65);
    cmp_model("t3_model");

    // Five-cycle GradValid stall in block 2.
    fill(0); set_grad(16); gv_mode = 2; do_load();
    we0 = we_tot; gr0 = gr20_tot;
    run_pass(-1, 0, -1, dc);
    chk("t4_gradreq_cycles", gr20_tot - gr0, 6);
    chk("t4_done_cycle", dc, 30);
    chk("t4_we_pulses", we_tot - we0, 6);
    cmp_model("t4_model");
    gv_mode = 0;

    // Start during the pass and during Done is ignored.
    fill(0); do_load();
    we0 = we_tot; dn0 = done_tot;
    run_pass(10, 1, -1, dc);
    chk("t5_done_cycle", dc, 25);
    chk("t5_we_pulses", we_tot - we0, 6);
    chk("t5_done_pulses", done_tot - dn0, 1);
    repeat (3) @(negedge Clock);
    chk("t5_still_idle", int'(bus.Busy), 0);

    // Reset in block 3's gradient wait, then a fresh full pass.
    fill(0); do_load();
    we0 = we_tot;
    run_pass(-1, 0, 3, dc);
    chk("t6_we_before_rst", we_tot - we0, 3);
    chk("t6_blocks012", count_eq(0, 29, -1), 30);
    chk("t6_blocks345", count_eq(30, 64, 0), 35);
    cmp_model("t6_model_rst");
    we0 = we_tot;
    run_pass(-1, 0, -1, dc);
    chk("t6_done_cycle", dc, 25);
    chk("t6_we_pulses", we_tot - we0, 6);
    chk("t6_blocks012_again", count_eq(0, 29, -2), 30);
    chk("t6_blocks345_again", count_eq(30, 59, -1), 30);
    cmp_model("t6_model");

    // Random weights, random gradients, random GradValid.
    gv_mode = 1; grad_rand = 1;
    for (int p = 0; p < 4; p++) begin
      for (int a = 0; a < DEPTH; a++) img[a] = int'($urandom_range(0, 1023)) - 512;
      do_load();
      we0 = we_tot; dn0 = done_tot;
      run_pass(-1, 0, -1, dc);
      chk("rand_we_pulses", we_tot - we0, 6);
      chk("rand_done_pulses", done_tot - dn0, 1);
      cmp_model("rand_model");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
